prog_loader: RTL

//  Writer/checker at the far end of the CPU's 4096x3 program RAM port: streams 3-bit words into
//  RAM, reads them back to verify, then releases the CPU. Holds the CPU in reset
//  (cpu_rst_n low) for the whole load, so the CPU never fetches a partial image.

---
 rtl/forth_pkg.sv | 7 +
 rtl/loader_chk.sv | 28 ++
 rtl/prog_loader.sv | 103 ++++++++++
 3 files changed

// File: rtl/forth_pkg.sv
// forth_pkg: shared widths, FSM state encoding and checksum width for the program loader.
package forth_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_WORD_W = 3;
  localparam int CHK_W = 2 * DEF_WORD_W;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, VERIFY = 2'd2, DRAIN = 2'd3} state_e;
endpackage

// File: rtl/loader_chk.sv
// loader_chk: running {sum mod 2**W, xor} fold over a word stream, cleared at load start.
module loader_chk
  import forth_pkg::*;
#(
  parameter int W = DEF_WORD_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic [W-1:0]   word,
  output logic [2*W-1:0] chk
);
  logic [W-1:0] sum_q, x_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      x_q   <= '0;
    end else if (clr) begin
      sum_q <= '0;
      x_q   <= '0;
    end else if (en) begin
      sum_q <= sum_q + word;
      x_q   <= x_q ^ word;
    end
  end
  assign chk = {sum_q, x_q};
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams words into program RAM, reads them back to verify the checksum,
// and holds the CPU in reset until a load verifies.
module prog_loader
  import forth_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int RD_LAT   = 1,
  parameter bit HOLD_RST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                cpu_rst_n,
  output logic [2*WORD_W-1:0] chk
);
  state_e                state_q;
  logic [ADDR_W-1:0]     ptr_q, base_q;
  logic [ADDR_W:0]       cnt_q, rem_q;
  logic [RD_LAT-1:0]     vpipe_q;
  logic                  done_q, err_q, cpu_rst_n_q;
  logic [2*WORD_W-1:0]   chk_q, wchk, rchk;
  logic                  cnt_ok, go, last;
  // legal count is 1..2**ADDR_W: nonzero, and if the top bit is set nothing below it is
  assign cnt_ok    = |count && !(count[ADDR_W] && |count[ADDR_W-1:0]);
  assign go        = state_q == IDLE && start && cnt_ok;
  assign last      = rem_q == (ADDR_W+1)'(1);
  assign in_ready  = state_q == LOAD;
  assign mem_we    = in_ready && in_valid;
  assign mem_addr  = ptr_q;
  assign mem_wdata = mem_we ? in_data : '0;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign chk       = chk_q;
  loader_chk #(.W(WORD_W)) u_wchk (
    .clk(clk), .rst_n(rst_n), .clr(go), .en(mem_we), .word(in_data), .chk(wchk)
  );
  loader_chk #(.W(WORD_W)) u_rchk (
    .clk(clk), .rst_n(rst_n), .clr(go), .en(vpipe_q[RD_LAT-1]), .word(mem_rdata), .chk(rchk)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      vpipe_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= ~HOLD_RST;
      chk_q       <= '0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      vpipe_q <= RD_LAT'({vpipe_q, state_q == VERIFY});
      case (state_q)
        IDLE: if (start) begin
          if (cnt_ok) begin
            state_q     <= LOAD;
            base_q      <= base_addr;
            ptr_q       <= base_addr;
            cnt_q       <= count;
            rem_q       <= count;
            cpu_rst_n_q <= 1'b0;
          end else err_q <= 1'b1;
        end
        LOAD: if (in_valid) begin
          ptr_q <= last ? base_q : ptr_q + ADDR_W'(1);
          rem_q <= last ? cnt_q : rem_q - (ADDR_W+1)'(1);
          if (last) state_q <= VERIFY;
        end
        VERIFY: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          rem_q <= rem_q - (ADDR_W+1)'(1);
          if (last) state_q <= DRAIN;
        end
        DRAIN: if (vpipe_q == '0) begin
          state_q <= IDLE;
          chk_q   <= wchk;
          if (rchk == wchk) begin
            done_q      <= 1'b1;
            cpu_rst_n_q <= 1'b1;
          end else err_q <= 1'b1;
        end
      endcase
    end
  end
endmodule
